// File: rtl/boton_eventos_if.sv
// Event handshake between boton_eventos and the pet control FSM.
// master drives valid/code, slave drives ready.
interface boton_eventos_if;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_ready;

  modport master (
    output evt_valid,
    output evt_code,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    output evt_ready
  );
endinterface

// File: rtl/boton_eventos.sv
// Button levels -> prioritised events (comida/medicina/test short/long).
// Optional BOTON_AUTOREPEAT_EN: auto-repeat for held comida/medicina.
module boton_eventos #(
  parameter int LONG_CYCLES   = 150000000,
  parameter int REPEAT_CYCLES = 25000000,
  parameter int CNT_W         = 28
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              test,
  input  logic              b_comida,
  input  logic              b_medicina,
  boton_eventos_if.master   evt,
  output logic              evt_perdido,
  output logic              modo_test
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    LARGO
  } t_state_e;

  t_state_e         state;
  logic [CNT_W-1:0] cnt;
  logic             prev_test;
  logic             prev_com;
  logic             prev_med;
  logic [3:0]       pend;
  logic [3:0]       sets;
  logic [3:0]       clr;
  logic [3:0]       drop;
  logic [3:0]       pend_nxt;
  logic [1:0]       sel;
  logic [1:0]       rep_fire;
  logic             load;
  logic             press_test;
  logic             press_com;
  logic             press_med;
  logic             set_corto;
  logic             set_largo;

  assign press_test = test & ~prev_test;
  assign press_com  = b_comida & ~prev_com;
  assign press_med  = b_medicina & ~prev_med;

  assign set_corto = (state == HELD) & ~test;
  assign set_largo = (state == HELD) & test & (cnt == LAST);

`ifdef BOTON_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REARM =
    CNT_W'(LONG_CYCLES - REPEAT_CYCLES);

  logic [1:0]       rep_act;
  logic [CNT_W-1:0] rep_cnt [2];
  logic [1:0]       btn;
  logic [1:0]       btn_press;

  assign btn       = {b_medicina, b_comida};
  assign btn_press = {press_med, press_com};

  always_comb begin
    rep_fire = '0;
    for (int i = 0; i < 2; i++)
      rep_fire[i] = rep_act[i] & btn[i] &
                    (rep_cnt[i] == LAST);
  end

  // after the first fire, rewind so the next one lands REPEAT_CYCLES later
  always_ff @(posedge clk) begin
    if (!reset) begin
      rep_act <= '0;
      for (int i = 0; i < 2; i++)
        rep_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!btn[i]) begin
          rep_act[i] <= 1'b0;
          rep_cnt[i] <= '0;
        end else if (btn_press[i]) begin
          rep_act[i] <= 1'b1;
          rep_cnt[i] <= '0;
        end else if (rep_act[i]) begin
          rep_cnt[i] <= rep_fire[i] ? REARM
                                    : rep_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  localparam int unused_repeat = REPEAT_CYCLES;
  assign rep_fire = 2'b00;
`endif

  assign sets = {set_largo,
                 set_corto,
                 press_med | rep_fire[1],
                 press_com | rep_fire[0]};

  assign load = ~evt.evt_valid | evt.evt_ready;

  always_comb begin
    sel = 2'd0;
    if (pend[3])      sel = 2'd3;
    else if (pend[2]) sel = 2'd2;
    else if (pend[1]) sel = 2'd1;
    clr = (load && |pend) ? (4'b0001 << sel) : 4'b0000;
  end

  // a flag being loaded this cycle can be re-set without a drop
  assign drop     = sets & pend & ~clr;
  assign pend_nxt = (pend & ~clr) | sets;

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_test     <= 1'b1;
      prev_com      <= 1'b1;
      prev_med      <= 1'b1;
      state         <= IDLE;
      cnt           <= '0;
      modo_test     <= 1'b0;
      pend          <= '0;
      evt_perdido   <= 1'b0;
      evt.evt_valid <= 1'b0;
      evt.evt_code  <= 2'd0;
    end else begin
      prev_test <= test;
      prev_com  <= b_comida;
      prev_med  <= b_medicina;

      unique case (state)
        IDLE: begin
          if (press_test) begin
            state <= HELD;
            cnt   <= '0;
          end
        end
        HELD: begin
          if (!test) begin
            state <= IDLE;
          end else if (cnt == LAST) begin
            state     <= LARGO;
            modo_test <= ~modo_test;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LARGO: begin
          if (!test) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      pend        <= pend_nxt;
      evt_perdido <= |drop;

      if (load) begin
        evt.evt_valid <= |pend;
        if (|pend) evt.evt_code <= sel;
      end
    end
  end

endmodule

// File: tb/tb_boton_eventos.sv
// Bench for boton_eventos: directed scenarios plus random stimulus
// compared every cycle against a hold-length based event model.
module tb_boton_eventos;

  localparam int L = 8;
  localparam int R = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic test = 1'b0;
  logic b_comida = 1'b0;
  logic b_medicina = 1'b0;
  logic evt_perdido;
  logic modo_test;

  boton_eventos_if bus ();

  boton_eventos #(
    .LONG_CYCLES  (L),
    .REPEAT_CYCLES(R),
    .CNT_W        (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .test       (test),
    .b_comida   (b_comida),
    .b_medicina (b_medicina),
    .evt        (bus.master),
    .evt_perdido(evt_perdido),
    .modo_test  (modo_test)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  bit cmp_en = 1'b0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // model: run[i] = consecutive high samples since a genuine press
  int run [3];
  bit last [3];
  bit [3:0] m_pend;
  bit m_valid;
  int m_code;
  bit m_perd;
  bit m_mode;

  always @(posedge clk) begin
    bit in_v [3];
    bit [3:0] s;
    bit [3:0] c;
    int pr;
    in_v[0] = b_comida;
    in_v[1] = b_medicina;
    in_v[2] = test;
    s = '0;
    c = '0;
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        run[i] = 0;
        last[i] = 1'b1;
      end
      m_pend = '0;
      m_valid = 1'b0;
      m_code = 0;
      m_perd = 1'b0;
      m_mode = 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        pr = run[i];
        if (!in_v[i]) run[i] = 0;
        else if (!last[i]) run[i] = 1;
        else if (run[i] > 0) run[i] = run[i] + 1;
        if (i < 2) begin
          if (run[i] == 1) s[i] = 1'b1;
`ifdef BOTON_AUTOREPEAT_EN
          if (run[i] > L && (run[i] - L - 1) % R == 0) s[i] = 1'b1;
`endif
        end else begin
          if (run[i] == L + 1) begin
            s[3] = 1'b1;
            m_mode = !m_mode;
          end
          if (!in_v[i] && pr >= 1 && pr <= L) s[2] = 1'b1;
        end
        last[i] = in_v[i];
      end
      if (!m_valid || bus.evt_ready) begin
        m_valid = 1'b0;
        for (int k = 3; k >= 0; k--) begin
          if (m_pend[k] && !m_valid) begin
            m_valid = 1'b1;
            m_code = k;
            c[k] = 1'b1;
          end
        end
      end
      m_perd = |(s & m_pend & ~c);
      m_pend = (m_pend & ~c) | s;
    end
  end

  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      chk("cyc_valid", int'(bus.evt_valid), int'(m_valid));
      chk("cyc_code", int'(bus.evt_code), m_code);
      chk("cyc_perdido", int'(evt_perdido), int'(m_perd));
      chk("cyc_modo", int'(modo_test), int'(m_mode));
    end
  end

  initial begin
    int n;
    int exp_rep;
    bus.evt_ready = 1'b1;
    tick(3);
    chk("rst_valid", int'(bus.evt_valid), 0);
    chk("rst_code", int'(bus.evt_code), 0);
    chk("rst_perdido", int'(evt_perdido), 0);
    chk("rst_modo", int'(modo_test), 0);
    reset = 1'b1;
    cmp_en = 1'b1;

    // single comida press
    tick(2);
    b_comida = 1'b1;
    tick();
    chk("s1_e0_valid", int'(bus.evt_valid), 0);
    tick();
    chk("s1_e1_valid", int'(bus.evt_valid), 1);
    chk("s1_e1_code", int'(bus.evt_code), 0);
    b_comida = 1'b0;
    tick();
    chk("s1_e2_valid", int'(bus.evt_valid), 0);

    // short test press
    tick(2);
    test = 1'b1;
    tick(3);
    test = 1'b0;
    tick();
    chk("s2_e3_valid", int'(bus.evt_valid), 0);
    tick();
    chk("s2_valid", int'(bus.evt_valid), 1);
    chk("s2_code", int'(bus.evt_code), 2);
    chk("s2_modo", int'(modo_test), 0);
    tick();
    chk("s2_after", int'(bus.evt_valid), 0);

    // long test press, held 20 cycles
    tick(2);
    test = 1'b1;
    tick(8);
    chk("s3_modo_e7", int'(modo_test), 0);
    tick();
    chk("s3_modo_e8", int'(modo_test), 1);
    chk("s3_e8_valid", int'(bus.evt_valid), 0);
    tick();
    chk("s3_valid", int'(bus.evt_valid), 1);
    chk("s3_code", int'(bus.evt_code), 3);
    tick(10);
    test = 1'b0;
    n = 0;
    repeat (6) begin
      tick();
      n += int'(bus.evt_valid);
    end
    chk("s3_no_release_evt", n, 0);
    chk("s3_modo_kept", int'(modo_test), 1);

    // back-pressure, priority order and dropped event
    bus.evt_ready = 1'b0;
    test = 1'b1;
    tick(9);
    chk("s4_modo_toggle", int'(modo_test), 0);
    tick();
    chk("s4_stall_code", int'(bus.evt_code), 3);
    test = 1'b0;
    tick(2);
    b_comida = 1'b1;
    b_medicina = 1'b1;
    tick();
    b_comida = 1'b0;
    tick();
    b_comida = 1'b1;
    tick();
    chk("s4_perdido", int'(evt_perdido), 1);
    tick();
    chk("s4_perdido_end", int'(evt_perdido), 0);
    chk("s4_held_valid", int'(bus.evt_valid), 1);
    chk("s4_held_code", int'(bus.evt_code), 3);
    bus.evt_ready = 1'b1;
    tick();
    chk("s4_second", int'(bus.evt_code), 1);
    tick();
    chk("s4_third", int'(bus.evt_code), 0);
    chk("s4_third_v", int'(bus.evt_valid), 1);
    tick();
    chk("s4_drained", int'(bus.evt_valid), 0);
    b_comida = 1'b0;
    b_medicina = 1'b0;

    // test held through reset
    tick(2);
    test = 1'b1;
    tick();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    n = 0;
    repeat (12) begin
      tick();
      n += int'(bus.evt_valid);
    end
    test = 1'b0;
    repeat (4) begin
      tick();
      n += int'(bus.evt_valid);
    end
    chk("s5_no_evt", n, 0);
    chk("s5_modo", int'(modo_test), 0);
    test = 1'b1;
    tick(2);
    test = 1'b0;
    tick(2);
    chk("s5_new_press", int'(bus.evt_code), 2);
    chk("s5_new_valid", int'(bus.evt_valid), 1);

    // comida held 20 cycles
    tick(3);
    n = 0;
    b_comida = 1'b1;
    repeat (20) begin
      tick();
      n += int'(bus.evt_valid);
    end
    b_comida = 1'b0;
    repeat (4) begin
      tick();
      n += int'(bus.evt_valid);
    end
`ifdef BOTON_AUTOREPEAT_EN
    exp_rep = 4;
`else
    exp_rep = 1;
`endif
    chk("s6_events", n, exp_rep);

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      tick();
      if ($urandom_range(0, 5) == 0) b_comida = ~b_comida;
      if ($urandom_range(0, 5) == 0) b_medicina = ~b_medicina;
      if ($urandom_range(0, 9) == 0) test = ~test;
      bus.evt_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 499) != 0);
    end
    reset = 1'b1;
    tick(2);
    cmp_en = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
